// File: rtl/router_switch_nxn.sv
// N-port word-wide packet switch: header-addressed routing, round-robin grant per output,
// cut-through forwarding with no buffering, host-visible enable mask and pkt/drop counters.
module router_switch_nxn #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_PORTS-1:0]          in_valid,
  input  logic [NUM_PORTS-1:0]          in_sop,
  input  logic [NUM_PORTS-1:0]          in_eop,
  input  logic [NUM_PORTS*DATA_W-1:0]   in_data,
  output logic [NUM_PORTS-1:0]          in_ready,
  output logic [NUM_PORTS-1:0]          out_valid,
  output logic [NUM_PORTS-1:0]          out_sop,
  output logic [NUM_PORTS-1:0]          out_eop,
  output logic [NUM_PORTS*DATA_W-1:0]   out_data,
  input  logic [NUM_PORTS-1:0]          out_ready,
  input  logic                          host_wr_en,
  input  logic                          host_rd_en,
  input  logic [7:0]                    host_addr,
  input  logic [15:0]                   host_wdata,
  output logic [15:0]                   host_rdata,
  output logic                          host_rd_valid
);
  localparam int PW = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {UNB = 2'd0, DRP = 2'd1, BND = 2'd2} in_st_e;

  in_st_e                          in_st   [NUM_PORTS];
  in_st_e                          in_st_n [NUM_PORTS];
  logic [NUM_PORTS-1:0]            busy, busy_n, mask, drop_inc, fwd, rel;
  logic [NUM_PORTS-1:0][PW-1:0]    own, own_n, rr, rr_n, dest;
  logic [NUM_PORTS-1:0][CNT_W-1:0] pkt_cnt, drop_cnt;
  logic [15:0]                     rd_val;
  logic [PW-1:0]                   idx;
  logic                            found;
  logic                            unused_wdata;

  assign unused_wdata = ^host_wdata;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_dest
    assign dest[i] = in_data[i*DATA_W +: PW];
  end

  // fwd: beat moves through output k this cycle; rel: that beat is the eop
  always_comb begin
    fwd = '0;
    rel = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      fwd[k] = busy[k] & in_valid[own[k]] & out_ready[k];
      rel[k] = fwd[k] & in_eop[own[k]];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      busy <= '0;
      own  <= '0;
      rr   <= '0;
      for (int i = 0; i < NUM_PORTS; i++) in_st[i] <= UNB;
    end else begin
      busy <= busy_n;
      own  <= own_n;
      rr   <= rr_n;
      for (int i = 0; i < NUM_PORTS; i++) in_st[i] <= in_st_n[i];
    end
  end

  always_comb begin
    busy_n   = busy;
    own_n    = own;
    rr_n     = rr;
    drop_inc = '0;
    idx      = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) in_st_n[i] = in_st[i];

    for (int k = 0; k < NUM_PORTS; k++) begin
      if (rel[k]) begin
        busy_n[k]         = 1'b0;
        rr_n[k]           = own[k] + PW'(1);
        in_st_n[own[k]]   = UNB;
      end
    end

    for (int i = 0; i < NUM_PORTS; i++) begin
      case (in_st[i])
        UNB: if (in_valid[i] && in_sop[i] && !mask[dest[i]]) begin
          drop_inc[i] = 1'b1;
          if (!in_eop[i]) in_st_n[i] = DRP;
        end
        DRP: if (in_valid[i] && in_eop[i]) in_st_n[i] = UNB;
        default: ;
      endcase
    end

    // grant only from IDLE, so a released output waits one cycle before re-granting
    for (int k = 0; k < NUM_PORTS; k++) begin
      found = 1'b0;
      if (!busy[k] && mask[k]) begin
        for (int j = 0; j < NUM_PORTS; j++) begin
          idx = rr[k] + PW'(j);
          if (!found && in_st[idx] == UNB && in_valid[idx] && in_sop[idx] &&
              dest[idx] == PW'(k)) begin
            found        = 1'b1;
            busy_n[k]    = 1'b1;
            own_n[k]     = idx;
            in_st_n[idx] = BND;
          end
        end
      end
    end
  end

  always_comb begin
    in_ready  = '0;
    out_valid = '0;
    out_sop   = '0;
    out_eop   = '0;
    out_data  = '0;
    if (reset) begin
      for (int i = 0; i < NUM_PORTS; i++)
        in_ready[i] = (in_st[i] == DRP) ||
                      (in_st[i] == UNB && !(in_valid[i] && in_sop[i] && mask[dest[i]]));
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (busy[k]) begin
          out_valid[k]                  = in_valid[own[k]];
          out_sop[k]                    = in_sop[own[k]];
          out_eop[k]                    = in_eop[own[k]];
          out_data[k*DATA_W +: DATA_W]  = in_data[own[k]*DATA_W +: DATA_W];
          in_ready[own[k]]              = out_ready[k];
        end
      end
    end
  end

  // host-side clear beats a same-cycle increment
  always_ff @(posedge clock) begin
    if (!reset) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (host_wr_en && host_addr == 8'(16 + k))
          pkt_cnt[k] <= '0;
        else if (rel[k] && pkt_cnt[k] != '1)
          pkt_cnt[k] <= pkt_cnt[k] + 1'b1;
        if (host_wr_en && host_addr == 8'(32 + k))
          drop_cnt[k] <= '0;
        else if (drop_inc[k] && drop_cnt[k] != '1)
          drop_cnt[k] <= drop_cnt[k] + 1'b1;
      end
    end
  end

  always_comb begin
    rd_val = '0;
    if (host_addr == 8'h00) rd_val[NUM_PORTS-1:0] = mask;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (host_addr == 8'(16 + k)) rd_val[CNT_W-1:0] = pkt_cnt[k];
      if (host_addr == 8'(32 + k)) rd_val[CNT_W-1:0] = drop_cnt[k];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      mask          <= '1;
      host_rdata    <= '0;
      host_rd_valid <= 1'b0;
    end else begin
      if (host_wr_en && host_addr == 8'h00) mask <= host_wdata[NUM_PORTS-1:0];
      host_rd_valid <= host_rd_en;
      host_rdata    <= host_rd_en ? rd_val : 16'h0000;
    end
  end

endmodule

// File: tb/tb_router_switch_nxn.sv
// Directed bench for router_switch_nxn (4 ports, 8-bit words, 4-bit counters so saturation is reachable).
module tb_router_switch_nxn;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = 4;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   in_valid, in_sop, in_eop, in_ready;
  logic [N-1:0]   out_valid, out_sop, out_eop, out_ready;
  logic [N*W-1:0] in_data, out_data;
  logic           host_wr_en, host_rd_en, host_rd_valid;
  logic [7:0]     host_addr;
  logic [15:0]    host_wdata, host_rdata;
  int             total = 0;
  int             bad   = 0;

  always #5 clock = ~clock;

  router_switch_nxn #(.NUM_PORTS(N), .DATA_W(W), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop), .out_data(out_data),
    .out_ready(out_ready),
    .host_wr_en(host_wr_en), .host_rd_en(host_rd_en), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_rd_valid(host_rd_valid)
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(int p, logic v, logic s, logic e, logic [7:0] d);
    in_valid[p]      = v;
    in_sop[p]        = s;
    in_eop[p]        = e;
    in_data[p*W +: W] = d;
  endtask

  function automatic logic [7:0] odata(int k);
    return out_data[k*W +: W];
  endfunction

  task automatic rd(string tag, logic [7:0] a, logic [15:0] exp);
    host_rd_en = 1'b1;
    host_addr  = a;
    step();
    host_rd_en = 1'b0;
    #1;
    chk(tag, host_rdata, exp);
    chk({tag, "_v"}, host_rd_valid, 1);
    step();
    chk({tag, "_v0"}, host_rd_valid, 0);
  endtask

  task automatic wr(logic [7:0] a, logic [15:0] d);
    host_wr_en = 1'b1;
    host_addr  = a;
    host_wdata = d;
    step();
    host_wr_en = 1'b0;
  endtask

  // entered just after the grant edge; forwards header + tail, checks the release bubble
  task automatic serve(int s, int d, logic [7:0] hdr, logic [7:0] tail);
    #1;
    chk("sv_hdr_v", out_valid[d], 1);
    chk("sv_hdr_d", odata(d), hdr);
    chk("sv_hdr_sop", out_sop[d], 1);
    chk("sv_own_rdy", in_ready[s], 1);
    step();
    drive(s, 1, 0, 1, tail);
    #1;
    chk("sv_tail_d", odata(d), tail);
    chk("sv_tail_eop", out_eop[d], 1);
    step();
    drive(s, 0, 0, 0, 8'h00);
    #1;
    chk("sv_bubble", out_valid[d], 0);
    step();
  endtask

  initial begin
    #50000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    in_valid = '0; in_sop = '0; in_eop = '0; in_data = '0;
    out_ready = '1;
    host_wr_en = 1'b0; host_rd_en = 1'b0; host_addr = '0; host_wdata = '0;
    step();
    in_valid = '1; in_sop = '1;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_rd_valid", host_rd_valid, 0);
    chk("rst_rdata", host_rdata, 0);
    step();
    in_valid = '0; in_sop = '0;
    reset = 1'b1;
    step();
    rd("rst_mask", 8'h00, 16'h000F);
    rd("rst_pkt2", 8'h12, 16'h0000);

    // 4-word packet from input 0 to output 2
    drive(0, 1, 1, 0, 8'h02);
    #1;
    chk("t1_wait_rdy", in_ready[0], 0);
    chk("t1_bubble", out_valid, 0);
    step();
    begin
      logic [7:0] w [4];
      w[0] = 8'h02; w[1] = 8'hA1; w[2] = 8'hB2; w[3] = 8'hC3;
      for (int b = 0; b < 4; b++) begin
        drive(0, 1, b == 0, b == 3, w[b]);
        #1;
        chk("t1_ov", out_valid, 4'b0100);
        chk("t1_data", odata(2), w[b]);
        chk("t1_sop", out_sop[2], b == 0);
        chk("t1_eop", out_eop[2], b == 3);
        step();
      end
    end
    drive(0, 0, 0, 0, 8'h00);
    #1;
    chk("t1_idle", out_valid, 0);
    rd("t1_pkt2", 8'h12, 16'h0001);

    // three contenders for output 1, then a wrapped pair
    drive(0, 1, 1, 0, 8'h01);
    drive(1, 1, 1, 0, 8'h11);
    drive(3, 1, 1, 0, 8'h31);
    #1;
    chk("t2_none", out_valid, 0);
    chk("t2_wait", in_ready & 4'b1011, 0);
    step();
    serve(0, 1, 8'h01, 8'hE0);
    serve(1, 1, 8'h11, 8'hE1);
    serve(3, 1, 8'h31, 8'hE3);
    drive(3, 1, 1, 0, 8'h31);
    drive(0, 1, 1, 0, 8'h01);
    step();
    serve(0, 1, 8'h01, 8'hF0);
    serve(3, 1, 8'h31, 8'hF3);
    rd("t2_pkt1", 8'h11, 16'h0005);

    // output 2 disabled: packet dropped; upper mask bits read back 0
    wr(8'h00, 16'hFFFB);
    rd("t3_mask", 8'h00, 16'h000B);
    for (int b = 0; b < 3; b++) begin
      drive(1, 1, b == 0, b == 2, (b == 0) ? 8'h02 : 8'h70);
      #1;
      chk("t3_rdy", in_ready[1], 1);
      chk("t3_ov", out_valid, 0);
      step();
    end
    drive(1, 0, 0, 0, 8'h00);
    drive(2, 1, 0, 0, 8'h5A);
    #1;
    chk("t3_stray_rdy", in_ready[2], 1);
    step();
    drive(2, 0, 0, 0, 8'h00);
    rd("t3_drop1", 8'h21, 16'h0001);
    rd("t3_drop2", 8'h22, 16'h0000);
    rd("t3_pkt2", 8'h12, 16'h0001);
    rd("t3_unmap", 8'h30, 16'h0000);
    rd("t3_unmap_k", 8'h14, 16'h0000);
    wr(8'h00, 16'h000F);

    // output 3 back-pressure mid-packet
    drive(2, 1, 1, 0, 8'h03);
    step();
    #1;
    chk("t4_hdr", odata(3), 8'h03);
    step();
    drive(2, 1, 0, 0, 8'h55);
    #1;
    chk("t4_w1", odata(3), 8'h55);
    step();
    drive(2, 1, 0, 0, 8'h66);
    out_ready[3] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t4_stall_rdy", in_ready[2], 0);
      chk("t4_stall_v", out_valid[3], 1);
      chk("t4_stall_d", odata(3), 8'h66);
      step();
    end
    out_ready[3] = 1'b1;
    #1;
    chk("t4_go_rdy", in_ready[2], 1);
    step();
    drive(2, 1, 0, 1, 8'h77);
    #1;
    chk("t4_w3", odata(3), 8'h77);
    chk("t4_eop", out_eop[3], 1);
    step();
    drive(2, 0, 0, 0, 8'h00);
    #1;
    chk("t4_done", out_valid[3], 0);
    rd("t4_pkt3", 8'h13, 16'h0001);

    // 16 single-word packets saturate the 4-bit pkt_cnt[0] at 15
    for (int p = 0; p < 16; p++) begin
      drive(1, 1, 1, 1, 8'h00);
      step();
      #1;
      chk("t5_ov", out_valid, 4'b0001);
      chk("t5_sopeop", {out_sop[0], out_eop[0]}, 2'b11);
      step();
      drive(1, 0, 0, 0, 8'h00);
    end
    rd("t5_sat", 8'h10, 16'h000F);
    host_rd_en = 1'b1; host_wr_en = 1'b1; host_addr = 8'h10;
    step();
    host_rd_en = 1'b0; host_wr_en = 1'b0;
    #1;
    chk("t5_rw_old", host_rdata, 16'h000F);
    rd("t5_cleared", 8'h10, 16'h0000);
    drive(1, 1, 1, 1, 8'h00);
    step();
    step();
    drive(1, 0, 0, 0, 8'h00);
    rd("t5_one", 8'h10, 16'h0001);
    drive(1, 1, 1, 1, 8'h00);
    step();
    host_wr_en = 1'b1; host_addr = 8'h10;
    #1;
    chk("t5_clr_beat", out_valid[0], 1);
    step();
    host_wr_en = 1'b0;
    drive(1, 0, 0, 0, 8'h00);
    rd("t5_clr_wins", 8'h10, 16'h0000);

    // reset during a BUSY transfer
    wr(8'h00, 16'h0009);
    drive(0, 1, 1, 0, 8'h03);
    step();
    #1;
    chk("t6_busy", out_valid, 4'b1000);
    step();
    drive(0, 1, 0, 0, 8'h44);
    reset = 1'b0;
    #1;
    chk("t6_rst_ov", out_valid, 0);
    chk("t6_rst_rdy", in_ready, 0);
    step();
    reset = 1'b1;
    drive(0, 0, 0, 0, 8'h00);
    #1;
    chk("t6_after_ov", out_valid, 0);
    rd("t6_mask", 8'h00, 16'h000F);
    rd("t6_pkt1", 8'h11, 16'h0000);
    rd("t6_drop1", 8'h21, 16'h0000);
    drive(2, 1, 1, 0, 8'h21);
    step();
    serve(2, 1, 8'h21, 8'hE2);
    rd("t6_pkt1_new", 8'h11, 16'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
